// File: rtl/exc_sequencer.sv
// exc_sequencer: sequencing stage behind exception control.
// It accepts a qualified exception request, latches the EPC and the cause,
// and issues a one-cycle PC redirect. On entry the redirect goes to a
// per-cause handler vector. On ERET, or on a debugger resume after a
// single-step halt, the redirect goes back to the saved EPC.
//
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   exc_we       - exception request (level), qualified by exc_cause/exc_ss
//   exc_pc       - resume PC saved into epc on acceptance
//   exc_cause    - cause code: 1 CF, 2 break, 3 div-by-zero, 4 single-step
//   exc_ss       - single-step flag, required for cause 4
//   eret         - ERET retire pulse, honoured only in HANDLER
//   step_resume  - debugger release pulse, honoured only in STEP
//   pc_redirect  - one-cycle strobe; fetch loads pc_target
//   pc_target    - redirect address (meaningful while pc_redirect is high)
//   epc, cause_q - architectural exception PC and cause
//   in_handler   - handler running
//   halt         - fetch/PC frozen during a single-step halt
//   exc_count    - accepted exceptions (wrapping)
//   drop_count   - ignored requests (saturating)
module exc_sequencer #(
  parameter logic [31:0] HANDLER_BASE = 32'h0000_0100,
  parameter int unsigned VEC_SHIFT    = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exc_we,
  input  logic [31:0]      exc_pc,
  input  logic [2:0]       exc_cause,
  input  logic             exc_ss,
  input  logic             eret,
  input  logic             step_resume,
  output logic             pc_redirect,
  output logic [31:0]      pc_target,
  output logic [31:0]      epc,
  output logic [2:0]       cause_q,
  output logic             in_handler,
  output logic             halt,
  output logic [CNT_W-1:0] exc_count,
  output logic [CNT_W-1:0] drop_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTER,
    S_HANDLER,
    S_RETURN,
    S_STEP
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      epc_q, epc_d;
  logic [2:0]       cause_qq, cause_d;
  logic [31:0]      pc_target_q, pc_target_d;
  logic [CNT_W-1:0] exc_count_q, exc_count_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic        req_valid;
  logic        accept;
  logic        drop;
  logic        leave_to_ret;
  logic [31:0] vec_addr;

  // Request qualification: causes 1..3 always, cause 4 only with exc_ss.
  always_comb begin
    req_valid = 1'b0;
    if (exc_we) begin
      unique case (exc_cause)
        3'd1, 3'd2, 3'd3: req_valid = 1'b1;
        3'd4:             req_valid = exc_ss;
        default:          req_valid = 1'b0;
      endcase
    end
  end

  // Only IDLE accepts a request. Every other exc_we pulse counts as dropped,
  // including attempts to nest while a handler is running.
  assign accept       = (state_q == S_IDLE) && req_valid;
  assign drop         = exc_we && !accept;
  assign leave_to_ret = ((state_q == S_HANDLER) && eret) ||
                        ((state_q == S_STEP) && step_resume);
  assign vec_addr     = HANDLER_BASE + (32'(exc_cause) << VEC_SHIFT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = (exc_cause == 3'd4) ? S_STEP : S_ENTER;
      end
      S_ENTER:   state_d = S_HANDLER;
      S_HANDLER: if (eret) state_d = S_RETURN;
      S_RETURN:  state_d = S_IDLE;
      S_STEP:    if (step_resume) state_d = S_RETURN;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode: every output comes from state or from a register.
  always_comb begin
    pc_redirect = (state_q == S_ENTER) || (state_q == S_RETURN);
    in_handler  = (state_q == S_HANDLER);
    halt        = (state_q == S_STEP);
  end

  // Datapath next values. pc_target is loaded one edge before the redirect
  // cycle, so the redirect appears registered in the cycle after the trigger.
  always_comb begin
    epc_d        = epc_q;
    cause_d      = cause_qq;
    pc_target_d  = pc_target_q;
    exc_count_d  = exc_count_q;
    drop_count_d = drop_count_q;
    if (accept) begin
      epc_d       = exc_pc;
      cause_d     = exc_cause;
      exc_count_d = exc_count_q + CNT_W'(1);
      if (exc_cause != 3'd4) pc_target_d = vec_addr;
    end
    if (leave_to_ret) pc_target_d = epc_q;
    if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epc_q        <= '0;
      cause_qq     <= '0;
      pc_target_q  <= '0;
      exc_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      epc_q        <= epc_d;
      cause_qq     <= cause_d;
      pc_target_q  <= pc_target_d;
      exc_count_q  <= exc_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign epc        = epc_q;
  assign cause_q    = cause_qq;
  assign pc_target  = pc_target_q;
  assign exc_count  = exc_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Testbench for exc_sequencer. Each record holds the inputs for one cycle
// and the outputs expected after the next rising edge. Expectations are
// queued when a record is driven and popped when the edge is checked.
module tb_exc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_we;
  logic [31:0] exc_pc;
  logic [2:0]  exc_cause;
  logic        exc_ss;
  logic        eret;
  logic        step_resume;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic [31:0] epc;
  logic [2:0]  cause_q;
  logic        in_handler;
  logic        halt;
  logic [15:0] exc_count;
  logic [15:0] drop_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  exc_sequencer #(
    .HANDLER_BASE(32'h0000_0100),
    .VEC_SHIFT   (4),
    .CNT_W       (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .exc_we     (exc_we),
    .exc_pc     (exc_pc),
    .exc_cause  (exc_cause),
    .exc_ss     (exc_ss),
    .eret       (eret),
    .step_resume(step_resume),
    .pc_redirect(pc_redirect),
    .pc_target  (pc_target),
    .epc        (epc),
    .cause_q    (cause_q),
    .in_handler (in_handler),
    .halt       (halt),
    .exc_count  (exc_count),
    .drop_count (drop_count)
  );

  typedef struct {
    logic        we;
    logic [31:0] pc;
    logic [2:0]  cause;
    logic        ss;
    logic        er;
    logic        rs;
    logic        x_redir;
    logic [31:0] x_target;
    logic [31:0] x_epc;
    logic [2:0]  x_cause;
    logic        x_inh;
    logic        x_halt;
    logic [15:0] x_exc;
    logic [15:0] x_drop;
  } vec_t;

  vec_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input vec_t e);
    chk("pc_redirect", 32'(pc_redirect), 32'(e.x_redir));
    if (e.x_redir) chk("pc_target", pc_target, e.x_target);
    chk("epc", epc, e.x_epc);
    chk("cause_q", 32'(cause_q), 32'(e.x_cause));
    chk("in_handler", 32'(in_handler), 32'(e.x_inh));
    chk("halt", 32'(halt), 32'(e.x_halt));
    chk("exc_count", 32'(exc_count), 32'(e.x_exc));
    chk("drop_count", 32'(drop_count), 32'(e.x_drop));
  endtask

  // Drive one record, push its expectation, clock, pop and compare.
  task automatic cyc(input vec_t v);
    vec_t e;
    exc_we      = v.we;
    exc_pc      = v.pc;
    exc_cause   = v.cause;
    exc_ss      = v.ss;
    eret        = v.er;
    step_resume = v.rs;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sb_q.pop_front();
      check_outputs(e);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] pc, input logic [2:0] cs,
                              input logic ss, input logic er, input logic rs,
                              input logic xr, input logic [31:0] xt, input logic [31:0] xe,
                              input logic [2:0] xc, input logic xi, input logic xh,
                              input logic [15:0] xx, input logic [15:0] xd);
    vec_t v;
    v.we = we; v.pc = pc; v.cause = cs; v.ss = ss; v.er = er; v.rs = rs;
    v.x_redir = xr; v.x_target = xt; v.x_epc = xe; v.x_cause = xc;
    v.x_inh = xi; v.x_halt = xh; v.x_exc = xx; v.x_drop = xd;
    return v;
  endfunction

  vec_t tbl[20];
  vec_t rec;

  initial begin
    //            we  pc        cs ss er rs | rdr target     epc        c  inh hlt exc drop
    tbl[0]  = mk(0, 32'h0,    0, 0, 0, 0,   0, 32'h0,    32'h0,    0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 32'h48,   1, 0, 0, 0,   1, 32'h110,  32'h48,   1, 0, 0, 1, 0);
    tbl[2]  = mk(0, 32'h0,    0, 0, 0, 0,   0, 32'h0,    32'h48,   1, 1, 0, 1, 0);
    tbl[3]  = mk(1, 32'h99,   3, 0, 0, 0,   0, 32'h0,    32'h48,   1, 1, 0, 1, 1);
    tbl[4]  = mk(1, 32'h99,   3, 0, 0, 0,   0, 32'h0,    32'h48,   1, 1, 0, 1, 2);
    tbl[5]  = mk(1, 32'h99,   3, 0, 0, 0,   0, 32'h0,    32'h48,   1, 1, 0, 1, 3);
    tbl[6]  = mk(1, 32'h99,   3, 0, 1, 0,   1, 32'h48,   32'h48,   1, 0, 0, 1, 4);
    tbl[7]  = mk(0, 32'h0,    0, 0, 0, 0,   0, 32'h0,    32'h48,   1, 0, 0, 1, 4);
    tbl[8]  = mk(1, 32'h500,  0, 0, 0, 0,   0, 32'h0,    32'h48,   1, 0, 0, 1, 5);
    tbl[9]  = mk(1, 32'h500,  6, 0, 0, 0,   0, 32'h0,    32'h48,   1, 0, 0, 1, 6);
    tbl[10] = mk(1, 32'h500,  4, 0, 0, 0,   0, 32'h0,    32'h48,   1, 0, 0, 1, 7);
    tbl[11] = mk(0, 32'h0,    0, 0, 1, 0,   0, 32'h0,    32'h48,   1, 0, 0, 1, 7);
    tbl[12] = mk(0, 32'h0,    0, 0, 0, 1,   0, 32'h0,    32'h48,   1, 0, 0, 1, 7);
    tbl[13] = mk(1, 32'h1000, 2, 0, 0, 0,   1, 32'h120,  32'h1000, 2, 0, 0, 2, 7);
    tbl[14] = mk(0, 32'h0,    0, 0, 0, 1,   0, 32'h0,    32'h1000, 2, 1, 0, 2, 7);
    tbl[15] = mk(0, 32'h0,    0, 0, 1, 0,   1, 32'h1000, 32'h1000, 2, 0, 0, 2, 7);
    tbl[16] = mk(0, 32'h0,    0, 0, 0, 0,   0, 32'h0,    32'h1000, 2, 0, 0, 2, 7);
    tbl[17] = mk(1, 32'h2000, 3, 0, 0, 0,   1, 32'h130,  32'h2000, 3, 0, 0, 3, 7);
    tbl[18] = mk(0, 32'h0,    0, 0, 0, 0,   0, 32'h0,    32'h2000, 3, 1, 0, 3, 7);
    tbl[19] = mk(0, 32'h0,    0, 0, 1, 0,   1, 32'h2000, 32'h2000, 3, 0, 0, 3, 7);

    rst_n = 1'b0; exc_we = 0; exc_pc = '0; exc_cause = '0; exc_ss = 0;
    eret = 0; step_resume = 0;
    repeat (2) @(posedge clk);
    #1;
    rec = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_outputs(rec);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) cyc(tbl[i]);
    cyc(mk(0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h2000, 3, 0, 0, 3, 7));

    // Single-step: halt without redirect, held 10 cycles with one dropped request.
    cyc(mk(1, 32'h20, 4, 1, 0, 0, 0, 32'h0, 32'h20, 4, 0, 1, 4, 7));
    for (int i = 0; i < 10; i++) begin
      if (i == 5) cyc(mk(1, 32'h77, 1, 0, 0, 0, 0, 32'h0, 32'h20, 4, 0, 1, 4, 8));
      else        cyc(mk(0, 32'h0,  0, 0, 1, 0, 0, 32'h0, 32'h20, 4, 0, 1, 4, (i > 5) ? 16'd8 : 16'd7));
    end
    cyc(mk(0, 32'h0, 0, 0, 0, 1, 1, 32'h20, 32'h20, 4, 0, 0, 4, 8));
    cyc(mk(0, 32'h0, 0, 0, 0, 0, 0, 32'h0,  32'h20, 4, 0, 0, 4, 8));

    // Reset asserted in STEP clears state immediately, without a clock edge.
    cyc(mk(1, 32'h40, 4, 1, 0, 0, 0, 32'h0, 32'h40, 4, 0, 1, 5, 8));
    exc_we = 0;
    #2;
    rst_n = 1'b0;
    #1;
    rec = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_outputs(rec);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(mk(1, 32'h48, 1, 0, 0, 0, 1, 32'h110, 32'h48, 1, 0, 0, 1, 0));
    cyc(mk(0, 32'h0,  0, 0, 0, 0, 0, 32'h0,   32'h48, 1, 1, 0, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
- Sequencing stage directly downstream of the exception control logic (EXControl).
- Consumes the combinational exception request (we, redirect PC, 3-bit cause, single-step flag) and latches EPC and cause into architectural registers.
- Drives a one-cycle PC redirect into the fetch stage: to a per-cause handler vector on entry, back to EPC on ERET, or holds fetch for a single-step breakpoint until the debugger resumes.
- Sits between exception control and the PC register / fetch mux.

Parameters:
- HANDLER_BASE, 32'h0000_0100, byte address of the cause-0 vector slot.
- VEC_SHIFT, 4, log2 of the byte spacing between handler vectors.
- CNT_W, 16, width of the exception and dropped-request counters.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- exc_we  in  1  exception request from exception control, level, sampled each cycle.
- exc_pc  in  32  PC to save as EPC (resume address).
- exc_cause  in  3  cause code; 1 = CF, 2 = break, 3 = divide-by-zero, 4 = single-step.
- exc_ss  in  1  single-step flag; qualifies cause 4.
- eret  in  1  one-cycle pulse from decode when ERET retires.
- step_resume  in  1  one-cycle debugger pulse that releases a single-step halt.
- pc_redirect  out  1  one-cycle strobe; fetch loads pc_target.
- pc_target  out  32  redirect address, valid only while pc_redirect is high.
- epc  out  32  saved exception PC.
- cause_q  out  3  latched cause.
- in_handler  out  1  high while the handler runs.
- halt  out  1  freezes fetch and PC during a single-step halt.
- exc_count  out  CNT_W  number of accepted exceptions.
- drop_count  out  CNT_W  number of requests ignored.

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE.
  - epc, pc_target, exc_count and drop_count clear to 0.
  - cause_q, pc_redirect, in_handler and halt clear to 0.
- A request is valid when exc_we = 1 and exc_cause is in 1..4.
  - Cause 4 is valid only if exc_ss = 1.
  - Any other combination with exc_we = 1 increments drop_count (saturating) and has no other effect.
- IDLE:
  - Valid request with cause 1..3: latch epc <= exc_pc and cause_q <= exc_cause, increment exc_count (wrapping), go to ENTER.
  - Valid request with cause 4: latch epc and cause_q, increment exc_count, go to STEP.
- ENTER (exactly 1 cycle):
  - pc_redirect = 1.
  - pc_target = HANDLER_BASE + (cause_q << VEC_SHIFT), computed in 32 bits with carry discarded.
  - Next state is HANDLER.
- HANDLER:
  - in_handler = 1.
  - Any exc_we = 1 is ignored (no nesting) and increments drop_count.
  - eret = 1: go to RETURN.
- RETURN (exactly 1 cycle):
  - pc_redirect = 1, pc_target = epc.
  - in_handler drops to 0 in this cycle.
  - Next state is IDLE.
  - A new request is accepted only from the following cycle onward.
- STEP:
  - halt = 1; exc_we is ignored and counted as dropped.
  - step_resume = 1: go to RETURN.
  - epc already equals the single-step resume PC, so fetch restarts there.
  - halt deasserts in the RETURN cycle.
- eret or step_resume in any state other than HANDLER or STEP respectively is ignored, not counted.
- Same-cycle eret and exc_we while in HANDLER: eret wins, the request is dropped.
- Latency:
  - Request in IDLE at edge N: redirect visible in cycle N+1.
  - eret at edge M: redirect visible in cycle M+1.
- Outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- Reset asserted mid-sequence (ENTER, HANDLER, STEP) aborts immediately: no redirect, halt drops, epc clears.

Test Plan:
- Reset, then exc_we = 1, cause = 1, exc_pc = 0x0000_0048 -> next cycle pc_redirect = 1, pc_target = 0x0000_0110; epc = 0x48, cause_q = 1, exc_count = 1, in_handler = 1 on the following cycle.
- In HANDLER, pulse eret -> one cycle pc_redirect = 1, pc_target = 0x48; then IDLE with in_handler = 0.
- exc_we = 1, cause = 4, exc_ss = 1, exc_pc = 0x0000_0020 -> halt = 1 with no redirect, held for 10 cycles; pulse step_resume -> pc_redirect with target 0x20, halt = 0.
- In HANDLER, drive exc_we = 1 with cause = 3 for 3 cycles -> drop_count = 3, epc and cause_q unchanged; eret arriving in the same cycle as exc_we -> return taken.
- exc_we = 1 with cause = 0 or cause = 6, and cause = 4 with exc_ss = 0 -> drop_count increments by 3, state stays IDLE, no redirect.
- Assert rst_n = 0 during STEP -> halt = 0 and epc = 0 immediately (asynchronously); after release, the block accepts a new request normally.
